// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_addsub_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_addsub4_fa_1b.sv
// One-bit full adder used as the serial datapath.
// Ports: a, b, ci (inputs) -> s (sum), co (carry out).
module fa_1b (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub4.sv
// Bit-serial add/subtract, one bit per clock, LSB first.
// Ports: clk, rst_n (async low), start, sub, a, b, cin in;
//        busy, done (1-cycle pulse), s, cout out.
// Optional: define SERIAL_ADDSUB_OVF_EN to add the signed
//        overflow output ovf.
module serial_addsub4
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             done_q, done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic fa_s;
   logic fa_co;

   fa_1b u_fa (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .ci (c_q),
      .s  (fa_s),
      .co (fa_co)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      s_d     = s_q;
      cout_d  = cout_q;
      done_d  = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               // subtract is a + ~b + 1
               b_d     = b ^ {WIDTH{sub}};
               c_d     = sub ? 1'b1 : cin;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = fa_co;
            r_d   = {fa_s, r_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
               s_d     = {fa_s, r_q[WIDTH-1:1]};
               cout_d  = fa_co;
`ifdef SERIAL_ADDSUB_OVF_EN
               // carry into MSB xor carry out of MSB
               ovf_d   = c_q ^ fa_co;
`endif
            end
         end
         DONE: begin
            // pulse is registered: high the cycle after DONE
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         r_q     <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign s    = s_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_addsub4.md
SERIAL_ADDSUB4 -- requirements
Module: serial_addsub4

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request; sampled only while idle.
REQ-005 SHALL have port: sub  input  1  0 = add, 1 = subtract; sampled with start.
REQ-006 SHALL have port: a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port: b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port: cin  input  1  carry-in for add; ignored when sub = 1.
REQ-009 SHALL have port: busy  output  1  high from the cycle after start is accepted until done.
REQ-010 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port: s  output  WIDTH  registered sum/difference.
REQ-012 SHALL have port: cout  output  1  final carry; for subtract, 1 = no borrow.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 In IDLE with start = 1 at an edge: SHALL latch a, b XOR {WIDTH{sub}}, carry = sub ? 1 : cin, clear the bit counter, and go to SHIFT.
REQ-015 In SHIFT: SHALL process one bit per cycle, LSB first, through a 1-bit full adder, shift the sum bit into the result register MSB-first, and update the carry register.
REQ-016 SHALL leave SHIFT after exactly WIDTH cycles, then spend exactly one cycle in DONE and return to IDLE.
REQ-017 Latency: done SHALL be high in the cycle following edge k+WIDTH+1, where k is the edge accepting start (cycle 6 for WIDTH = 4); it SHALL be low in all other cycles.
REQ-018 s and cout SHALL update only when DONE is entered, and SHALL hold until the next DONE.
REQ-019 start SHALL be ignored while busy or in DONE; there is no queueing.
REQ-020 Input changes on a, b, sub, or cin after acceptance SHALL NOT affect the result in progress.
REQ-021 Arithmetic: {cout, s} SHALL equal a + b + cin for add, and a + ~b + 1 modulo 2^(WIDTH+1) for subtract.
REQ-022 Wrap-around: results SHALL wrap modulo 2^WIDTH in s, with the carry reported only on cout.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, busy = 0, done = 0, s = 0, cout = 0, and clear all internal registers (and ovf = 0 when present).
REQ-024 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow.
REQ-025 The first start SHALL be accepted at the first rising edge with rst_n high.

Configuration
REQ-026 Macro SERIAL_ADDSUB_OVF_EN defined: SHALL add output port ovf  output  1  two's-complement signed overflow, computed as the carry into the MSB XOR the carry out of the MSB, and updated and held like cout.
REQ-027 Macro SERIAL_ADDSUB_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 The shared package serial_addsub_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the default-WIDTH constant.
REQ-029 The single sub-module fa_1b (a, b, ci -> s, co) SHALL perform the per-bit addition, instantiated once.

Verification
REQ-030 a = 0001, b = 1101, cin = 1, sub = 0 -> s = 1111, cout = 0, done pulse in cycle 6 after start.
REQ-031 a = 0101, b = 0011, sub = 1, cin = 1 -> s = 0010, cout = 1; a = 0011, b = 0101, sub = 1 -> s = 1110, cout = 0.
REQ-032 a = 1111, b = 0000, cin = 1, sub = 0 -> s = 0000, cout = 1; with OVF_EN, a = 0111, b = 0001, cin = 0 -> s = 1000, ovf = 1.
REQ-033 start pulsed again in cycle 3 with different operands -> ignored; exactly one done pulse, carrying the first result.
REQ-034 rst_n low in cycle 3 of an operation -> busy = 0, s = 0, cout = 0 immediately; no done pulse; the next start completes normally.
REQ-035 a and b changed every cycle during SHIFT -> result equals the values sampled at start.
